// File: rtl/opl3_slot_sequencer.sv
// opl3_slot_sequencer
//   Time-division scheduler for the shared OPL3 operator datapath. Every
//   sample_clk_en pulse starts one frame that issues all 36 operator slots
//   (bank 0 ops 0-17, then bank 1 ops 0-17) over a valid/ready + done
//   handshake. Host register writes are buffered in a small FIFO and are only
//   drained into the register file while no frame is running, so operator
//   parameters never change in the middle of a sample.
//
// Configuration macro:
//   OPL3_SEQ_OVERRUN_CNT_EN - when defined, overrun_cnt counts dropped
//   sample_clk_en pulses (saturating). When undefined, overrun_cnt is tied to 0.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   sample_clk_en  one-cycle pulse per sample period; starts a frame from IDLE
//   host_wr_*      host register write request (valid/bank/addr/data)
//   host_wr_ready  FIFO can accept a write (not full)
//   reg_wr         register-file write; valid is a one-cycle pulse
//   slot_valid     slot issue request, with slot_bank / slot_op_num
//   slot_ready     datapath accepts the issued slot
//   slot_done      datapath finished the accepted slot
//   frame_done     one-cycle pulse once slot 35 has completed
//   busy           frame in progress
//   overrun        sticky: sample_clk_en arrived while busy
//   overrun_cnt    number of dropped sample_clk_en pulses (macro build only)

typedef struct packed {
  logic       valid;
  logic       bank;
  logic [7:0] addr;
  logic [7:0] data;
} opl3_reg_wr_t;

module opl3_slot_sequencer #(
  parameter int WR_FIFO_DEPTH = 4,
  parameter int OVERRUN_CNT_W = 16,
  localparam int OP_NUM_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_clk_en,
  input  logic                     host_wr_valid,
  input  logic                     host_wr_bank,
  input  logic [7:0]               host_wr_addr,
  input  logic [7:0]               host_wr_data,
  output logic                     host_wr_ready,
  output opl3_reg_wr_t             reg_wr,
  output logic                     slot_valid,
  output logic                     slot_bank,
  output logic [OP_NUM_WIDTH-1:0]  slot_op_num,
  input  logic                     slot_ready,
  input  logic                     slot_done,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overrun,
  output logic [OVERRUN_CNT_W-1:0] overrun_cnt
);

  localparam int PTR_W = $clog2(WR_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WR_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
  localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = 5'd17;
  localparam logic [7:0] LAST_REG_ADDR = 8'hF5;
  localparam opl3_reg_wr_t REG_WR_IDLE = '{valid: 1'b0, bank: 1'b0, addr: 8'h00, data: 8'h00};

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_FRAME_END = 2'd3;

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic                    bank_r;
  logic                    bank_nxt_s;
  logic [OP_NUM_WIDTH-1:0] op_r;
  logic [OP_NUM_WIDTH-1:0] op_nxt_s;
  logic                    slot_valid_r;
  logic                    frame_done_r;
  logic                    busy_r;
  logic                    overrun_r;
  opl3_reg_wr_t            reg_wr_r;

  // FIFO entries hold {bank, addr, data}
  logic [16:0]             mem_r [WR_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        count_nxt_s;
  logic                    host_wr_ready_r;
  logic                    push_s;
  logic                    pop_s;

  // Out-of-range addresses complete the handshake but are dropped here.
  assign push_s = host_wr_valid & host_wr_ready_r & (host_wr_addr <= LAST_REG_ADDR);

  // Next-state, slot counter and FIFO pop decision
  always_comb begin
    state_nxt_s = state_r;
    bank_nxt_s  = bank_r;
    op_nxt_s    = op_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A new frame takes priority; pending writes wait for the next IDLE.
        if (sample_clk_en) begin
          state_nxt_s = ST_ISSUE;
          bank_nxt_s  = 1'b0;
          op_nxt_s    = {OP_NUM_WIDTH{1'b0}};
        end else if (count_r != EMPTY_CNT) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (slot_ready) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (slot_done) begin
          if (bank_r && (op_r == LAST_OP)) begin
            state_nxt_s = ST_FRAME_END;
          end else if (op_r == LAST_OP) begin
            state_nxt_s = ST_ISSUE;
            bank_nxt_s  = 1'b1;
            op_nxt_s    = {OP_NUM_WIDTH{1'b0}};
          end else begin
            state_nxt_s = ST_ISSUE;
            op_nxt_s    = op_r + 1'b1;
          end
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_FRAME_END: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FSM state and registered slot/frame outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bank_r       <= 1'b0;
      op_r         <= {OP_NUM_WIDTH{1'b0}};
      slot_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      reg_wr_r     <= REG_WR_IDLE;
    end else begin
      state_r      <= state_nxt_s;
      bank_r       <= bank_nxt_s;
      op_r         <= op_nxt_s;
      slot_valid_r <= (state_nxt_s == ST_ISSUE);
      frame_done_r <= (state_nxt_s == ST_FRAME_END);
      busy_r       <= (state_nxt_s != ST_IDLE);
      if (pop_s) begin
        reg_wr_r <= '{valid: 1'b1, bank: mem_r[rd_ptr_r][16],
                      addr: mem_r[rd_ptr_r][15:8], data: mem_r[rd_ptr_r][7:0]};
      end else begin
        reg_wr_r <= REG_WR_IDLE;
      end
    end
  end

  // FIFO pointers, occupancy and ready flag; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r        <= {PTR_W{1'b0}};
      rd_ptr_r        <= {PTR_W{1'b0}};
      count_r         <= EMPTY_CNT;
      host_wr_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r         <= count_nxt_s;
      host_wr_ready_r <= (count_nxt_s != FULL_CNT);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {host_wr_bank, host_wr_addr, host_wr_data};
    end
  end

  // Sticky overrun flag: a sample pulse outside IDLE is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (sample_clk_en && (state_r != ST_IDLE)) begin
      overrun_r <= 1'b1;
    end
  end

`ifdef OPL3_SEQ_OVERRUN_CNT_EN
  logic [OVERRUN_CNT_W-1:0] overrun_cnt_r;

  // Saturating count of dropped sample pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt_r <= {OVERRUN_CNT_W{1'b0}};
    end else if (sample_clk_en && (state_r != ST_IDLE) && (overrun_cnt_r != {OVERRUN_CNT_W{1'b1}})) begin
      overrun_cnt_r <= overrun_cnt_r + 1'b1;
    end
  end

  assign overrun_cnt = overrun_cnt_r;
`else
  assign overrun_cnt = {OVERRUN_CNT_W{1'b0}};
`endif

  assign host_wr_ready = host_wr_ready_r;
  assign reg_wr        = reg_wr_r;
  assign slot_valid    = slot_valid_r;
  assign slot_bank     = bank_r;
  assign slot_op_num   = op_r;
  assign frame_done    = frame_done_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;

endmodule
